// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage, its branch resolver, instruction memory and decode.
// Handshakes: a decode transfer happens on a cycle where out_valid && out_ready; once
// out_valid rises, out_instr/out_pc/out_pc4 hold until that transfer or a redirect squashes them.
// A memory read is requested while imem_ren is high and completes on the cycle imem_valid is high;
// imem_addr holds steady from the request until that completion.
interface fetch_unit_if;
    logic        redirect_en;
    logic [31:0] redirect_addr;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        fault;
    logic [1:0]  dbg_state;

    modport master (
        input  redirect_en, redirect_addr, imem_rdata, imem_valid, out_ready,
        output imem_ren, imem_addr, out_valid, out_instr, out_pc, out_pc4, fault, dbg_state
    );

    modport slave (
        output redirect_en, redirect_addr, imem_rdata, imem_valid, out_ready,
        input  imem_ren, imem_addr, out_valid, out_instr, out_pc, out_pc4, fault, dbg_state
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads, squashes stale fetches on redirect,
// and traps permanently on a misaligned redirect target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         nRST,
    fetch_unit_if.master bus
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend;
    logic        r_out_valid;
    logic [31:0] r_instr;
    logic [31:0] r_out_pc;
    logic [31:0] r_out_pc4;
    logic        r_fault;

    logic        w_misalign;
    logic [31:0] w_pc4;

    assign w_misalign = (bus.redirect_addr[1:0] != 2'b00);
    assign w_pc4      = r_pc + 32'd4;

    assign bus.imem_ren  = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign bus.imem_addr = r_pc;
    assign bus.out_valid = r_out_valid;
    assign bus.out_instr = r_instr;
    assign bus.out_pc    = r_out_pc;
    assign bus.out_pc4   = r_out_pc4;
    assign bus.fault     = r_fault;
    assign bus.dbg_state = r_state;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_pend      <= RESET_PC;
            r_out_valid <= 1'b0;
            r_instr     <= 32'd0;
            r_out_pc    <= 32'd0;
            r_out_pc4   <= 32'd0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (bus.redirect_en) begin
                        if (w_misalign) begin
                            // An unanswered read must still be drained before trapping.
                            r_fault <= 1'b1;
                            r_state <= bus.imem_valid ? S_FAULT : S_DRAIN;
                        end else if (bus.imem_valid) begin
                            r_pc <= bus.redirect_addr;
                        end else begin
                            r_pend  <= bus.redirect_addr;
                            r_state <= S_DRAIN;
                        end
                    end else if (bus.imem_valid) begin
                        r_instr     <= bus.imem_rdata;
                        r_out_pc    <= r_pc;
                        r_out_pc4   <= w_pc4;
                        r_pc        <= w_pc4;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // A redirect squashes the held instruction even if decode accepts it this cycle.
                    if (bus.redirect_en) begin
                        r_out_valid <= 1'b0;
                        if (w_misalign) begin
                            r_fault <= 1'b1;
                            r_state <= S_FAULT;
                        end else begin
                            r_pc    <= bus.redirect_addr;
                            r_state <= S_REQ;
                        end
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (bus.imem_valid) begin
                        if (r_fault || (bus.redirect_en && w_misalign)) begin
                            r_fault <= 1'b1;
                            r_state <= S_FAULT;
                        end else begin
                            r_pc    <= bus.redirect_en ? bus.redirect_addr : r_pend;
                            r_state <= S_REQ;
                        end
                    end else if (bus.redirect_en && !r_fault) begin
                        if (w_misalign) begin
                            r_fault <= 1'b1;
                        end else begin
                            r_pend <= bus.redirect_addr;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a transaction model.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (.CLK(clk), .nRST(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    // memory environment
    int lat = 0;
    int wait_cnt = 0;
    bit const_data = 1'b0;

    // reference model: flags describing what the stage is doing, not an encoded state
    logic [31:0] m_pc, m_pend, m_instr, m_opc;
    bit m_hold, m_drain, m_fault, m_dead;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (const_data) return 32'h0000_0013;
        return (a ^ 32'hC0DE_0000) + 32'h11;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_pend = 32'h0; m_instr = 32'h0; m_opc = 32'h0;
        m_hold = 0; m_drain = 0; m_fault = 0; m_dead = 0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] d, input bit re,
                              input logic [31:0] ra, input bit rdy);
        bit mis;
        mis = (ra % 4) != 0;
        if (m_dead) return;
        if (m_hold) begin
            if (re) begin
                m_hold = 0;
                if (mis) begin m_fault = 1; m_dead = 1; end
                else m_pc = ra;
            end else if (rdy) begin
                m_hold = 0;
            end
        end else if (m_drain) begin
            if (re && !m_fault) begin
                if (mis) m_fault = 1;
                else m_pend = ra;
            end
            if (v) begin
                m_drain = 0;
                if (m_fault) m_dead = 1;
                else m_pc = m_pend;
            end
        end else begin
            if (re) begin
                if (mis) begin
                    m_fault = 1;
                    if (v) m_dead = 1; else m_drain = 1;
                end else if (v) m_pc = ra;
                else begin m_drain = 1; m_pend = ra; end
            end else if (v) begin
                m_instr = d; m_opc = m_pc; m_pc = m_pc + 32'd4; m_hold = 1;
            end
        end
    endtask

    // Called at a falling edge: drives inputs for the next rising edge, returns at the next falling edge.
    task automatic tick(input bit re, input logic [31:0] ra, input bit rdy);
        bit v;
        logic [31:0] d;
        v = 1'b0;
        d = $urandom;
        if (bus.imem_ren) begin
            if (wait_cnt >= lat) begin
                v = 1'b1; d = mem_data(bus.imem_addr); wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        bus.imem_valid = v; bus.imem_rdata = d;
        bus.redirect_en = re; bus.redirect_addr = ra; bus.out_ready = rdy;
        model_step(v, d, re, ra, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.redirect_en = 0; bus.redirect_addr = 0; bus.out_ready = 0;
        bus.imem_valid = 0; bus.imem_rdata = 0;
        model_reset();
        wait_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({bus.imem_ren, bus.imem_addr, bus.out_valid, bus.fault} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_ctrl ren/addr/valid/fault got %b/%h/%b/%b", bus.imem_ren, bus.imem_addr, bus.out_valid, bus.fault);
        end
        n_tests++;
        if ({bus.out_instr, bus.out_pc, bus.out_pc4} !== 96'h0) begin
            n_fail++; $display("FAIL reset_out instr/pc/pc4 got %h/%h/%h want 0", bus.out_instr, bus.out_pc, bus.out_pc4);
        end
    endtask

    task automatic test_sequential();
        lat = 0; const_data = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] pc;
            pc = 32'(i * 4);
            n_tests++;
            if ({bus.imem_ren, bus.imem_addr, bus.out_valid} !== {1'b1, pc, 1'b0}) begin
                n_fail++; $display("FAIL seq_req%0d ren/addr/valid got %b/%h/%b want 1/%h/0", i, bus.imem_ren, bus.imem_addr, bus.out_valid, pc);
            end
            tick(0, 0, 1);
            n_tests++;
            if ({bus.out_valid, bus.out_instr, bus.out_pc, bus.out_pc4, bus.imem_ren} !== {1'b1, 32'h13, pc, pc + 32'd4, 1'b0}) begin
                n_fail++; $display("FAIL seq_out%0d valid/instr/pc/pc4 got %b/%h/%h/%h want 1/00000013/%h/%h", i, bus.out_valid, bus.out_instr, bus.out_pc, bus.out_pc4, pc, pc + 32'd4);
            end
            tick(0, 0, 1);
        end
        n_tests++;
        if (bus.imem_addr !== 32'hC) begin
            n_fail++; $display("FAIL seq_next addr got %h want 0000000c", bus.imem_addr);
        end
        const_data = 1'b0;
    endtask

    task automatic test_hold_stall();
        lat = 0;
        tick(1, 32'h10, 0);
        tick(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if ({bus.out_valid, bus.out_pc, bus.out_pc4, bus.out_instr, bus.imem_ren, bus.imem_addr} !==
                {1'b1, 32'h10, 32'h14, mem_data(32'h10), 1'b0, 32'h14}) begin
                n_fail++; $display("FAIL stall%0d valid/pc/pc4/instr/ren/addr got %b/%h/%h/%h/%b/%h", i, bus.out_valid, bus.out_pc, bus.out_pc4, bus.out_instr, bus.imem_ren, bus.imem_addr);
            end
            tick(0, 0, 0);
        end
        tick(0, 0, 1);
        n_tests++;
        if ({bus.imem_ren, bus.imem_addr, bus.out_valid} !== {1'b1, 32'h14, 1'b0}) begin
            n_fail++; $display("FAIL stall_release ren/addr/valid got %b/%h/%b want 1/00000014/0", bus.imem_ren, bus.imem_addr, bus.out_valid);
        end
    endtask

    task automatic test_redirect_drain();
        lat = 0;
        tick(1, 32'h40, 1);
        lat = 3;
        tick(1, 32'h200, 1);
        for (int k = 0; k < 10 && bus.imem_addr == 32'h40; k++) begin
            n_tests++;
            if ({bus.imem_ren, bus.out_valid} !== 2'b10) begin
                n_fail++; $display("FAIL drain_hold%0d ren/valid got %b/%b want 1/0", k, bus.imem_ren, bus.out_valid);
            end
            tick(0, 0, 1);
        end
        n_tests++;
        if ({bus.imem_ren, bus.imem_addr, bus.out_valid} !== {1'b1, 32'h200, 1'b0}) begin
            n_fail++; $display("FAIL drain_target ren/addr/valid got %b/%h/%b want 1/00000200/0", bus.imem_ren, bus.imem_addr, bus.out_valid);
        end
        for (int k = 0; k < 10 && !bus.out_valid; k++) tick(0, 0, 0);
        n_tests++;
        if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 32'h200, mem_data(32'h200)}) begin
            n_fail++; $display("FAIL drain_first valid/pc/instr got %b/%h/%h want 1/00000200/%h", bus.out_valid, bus.out_pc, bus.out_instr, mem_data(32'h200));
        end
        tick(0, 0, 1);
    endtask

    task automatic test_redirect_same_cycle();
        lat = 0;
        tick(1, 32'h300, 1);
        n_tests++;
        if ({bus.out_valid, bus.imem_ren, bus.imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
            n_fail++; $display("FAIL redir_req valid/ren/addr got %b/%b/%h want 0/1/00000300", bus.out_valid, bus.imem_ren, bus.imem_addr);
        end
        tick(0, 0, 0);
        n_tests++;
        if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'h300}) begin
            n_fail++; $display("FAIL redir_fill valid/pc got %b/%h want 1/00000300", bus.out_valid, bus.out_pc);
        end
        tick(1, 32'h300, 1);
        n_tests++;
        if ({bus.out_valid, bus.imem_ren, bus.imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
            n_fail++; $display("FAIL redir_hold valid/ren/addr got %b/%b/%h want 0/1/00000300", bus.out_valid, bus.imem_ren, bus.imem_addr);
        end
    endtask

    task automatic test_double_redirect();
        lat = 4;
        tick(1, 32'h500, 1);
        tick(1, 32'h600, 1);
        for (int k = 0; k < 10 && bus.imem_addr == 32'h300; k++) tick(0, 0, 1);
        n_tests++;
        if ({bus.imem_ren, bus.imem_addr, bus.out_valid} !== {1'b1, 32'h600, 1'b0}) begin
            n_fail++; $display("FAIL latest_wins ren/addr/valid got %b/%h/%b want 1/00000600/0", bus.imem_ren, bus.imem_addr, bus.out_valid);
        end
    endtask

    task automatic test_fault();
        lat = 0;
        tick(1, 32'h102, 1);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({bus.fault, bus.imem_ren, bus.out_valid, bus.imem_addr} !== {1'b1, 1'b0, 1'b0, 32'h600}) begin
                n_fail++; $display("FAIL fault_sticky%0d fault/ren/valid/addr got %b/%b/%b/%h want 1/0/0/00000600", i, bus.fault, bus.imem_ren, bus.out_valid, bus.imem_addr);
            end
            tick(1, 32'h400, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.fault, bus.imem_ren, bus.imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL fault_async_reset fault/ren/addr got %b/%b/%h want 0/1/00000000", bus.fault, bus.imem_ren, bus.imem_addr);
        end
        do_reset();
        lat = 3;
        tick(1, 32'h103, 1);
        n_tests++;
        if ({bus.fault, bus.imem_ren, bus.imem_addr} !== {1'b1, 1'b1, 32'h0}) begin
            n_fail++; $display("FAIL fault_drain fault/ren/addr got %b/%b/%h want 1/1/00000000", bus.fault, bus.imem_ren, bus.imem_addr);
        end
        for (int k = 0; k < 10 && bus.imem_ren; k++) tick(1, 32'h700, 1);
        tick(0, 0, 1);
        n_tests++;
        if ({bus.fault, bus.imem_ren, bus.out_valid, bus.imem_addr} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL fault_after_drain fault/ren/valid/addr got %b/%b/%b/%h want 1/0/0/00000000", bus.fault, bus.imem_ren, bus.out_valid, bus.imem_addr);
        end
        do_reset();
    endtask

    task automatic test_wrap();
        lat = 0;
        tick(1, 32'hFFFF_FFFC, 1);
        tick(0, 0, 0);
        n_tests++;
        if ({bus.out_valid, bus.out_pc, bus.out_pc4, bus.imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0}) begin
            n_fail++; $display("FAIL wrap_out valid/pc/pc4/addr got %b/%h/%h/%h want 1/fffffffc/0/0", bus.out_valid, bus.out_pc, bus.out_pc4, bus.imem_addr);
        end
        tick(0, 0, 1);
        n_tests++;
        if ({bus.imem_ren, bus.imem_addr} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL wrap_next ren/addr got %b/%h want 1/00000000", bus.imem_ren, bus.imem_addr);
        end
    endtask

    task automatic test_random();
        logic [33:0] exp_c, act_c;
        logic [95:0] exp_o, act_o;
        logic [31:0] r;
        do_reset();
        lat = $urandom_range(0, 3);
        for (int i = 0; i < 600; i++) begin
            exp_c = {!m_dead && !m_hold, m_pc, m_fault};
            act_c = {bus.imem_ren, bus.imem_addr, bus.fault};
            n_tests++;
            if (act_c !== exp_c || bus.out_valid !== m_hold) begin
                n_fail++; $display("FAIL rand_ctrl cyc%0d ren/addr/fault/valid got %h/%b want %h/%b", i, act_c, bus.out_valid, exp_c, m_hold);
            end
            if (m_hold) begin
                exp_o = {m_instr, m_opc, m_opc + 32'd4};
                act_o = {bus.out_instr, bus.out_pc, bus.out_pc4};
                n_tests++;
                if (act_o !== exp_o) begin
                    n_fail++; $display("FAIL rand_out cyc%0d instr/pc/pc4 got %h want %h", i, act_o, exp_o);
                end
            end
            if (m_dead && $urandom_range(0, 3) == 0) begin
                do_reset();
                lat = $urandom_range(0, 3);
            end else begin
                r = $urandom;
                if ($urandom_range(0, 29) != 0) r[1:0] = 2'b00;
                tick($urandom_range(0, 5) == 0, r, $urandom_range(0, 2) != 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect_drain();
        test_redirect_same_cycle();
        test_double_redirect();
        test_fault();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
